resp_signature_collector: RTL and testbench

- Receiving end of the stimulus/response path. Sits on the DUT output bus `y` in the identity simulation flow.
- Accepts one wide response word per valid/ready handshake and folds it, one chunk per cycle, into a MISR signature.
- Counts accepted samples. After a programmed number of samples, compares the signature against an expected value and reports pass/fail with a sticky done flag.
- Replaces per-cycle `$strobe` dumps with a synthesizable, self-checking collector.

---
 rtl/resp_signature_collector.sv | 118 +++++++++++
 tb/tb_resp_signature_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_signature_collector.sv
// Response signature collector: accepts wide words via valid/ready, folds them chunk by chunk into a MISR,
// then compares against exp_sig. Optional macro RESP_CAPTURE_LAST_EN builds the last_data capture register.
module resp_signature_collector #(
  parameter int          DATA_W      = 635,
  parameter int          CHUNK_W     = 32,
  parameter int          NUM_SAMPLES = 22,
  parameter logic [31:0] SEED        = 32'hFFFFFFFF,
  parameter logic [31:0] POLY        = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       exp_sig,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [31:0]       sig,
  output logic [15:0]       sample_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] last_data
);

  localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [15:0]      LAST_CNT = 16'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_FOLD, S_CHECK, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PAD_W-1:0]  shreg;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       sig_fold;
  logic              start_run;
  logic              take;
  logic              last_chunk;

  assign start_run  = start && (state == S_IDLE || state == S_DONE);
  assign take       = (state == S_ACCEPT) && in_valid;
  assign last_chunk = (idx == LAST_IDX);
  // The low chunk of the shift register is always the next one to fold.
  assign sig_fold   = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ shreg[CHUNK_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)    state_nxt = S_ACCEPT;
      S_ACCEPT:       if (in_valid) state_nxt = S_FOLD;
      S_FOLD:         if (last_chunk)
                        state_nxt = (sample_cnt == LAST_CNT) ? S_CHECK : S_ACCEPT;
      S_CHECK:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_ACCEPT:        begin in_ready = 1'b1; busy = 1'b1; end
      S_FOLD, S_CHECK: busy = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig        <= '0;
      sample_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      idx        <= '0;
    end else begin
      if (start_run) begin
        sig        <= SEED;
        sample_cnt <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
      end
      if (take) idx <= '0;
      if (state == S_FOLD) begin
        sig <= sig_fold;
        idx <= idx + 1'b1;
        if (last_chunk) sample_cnt <= sample_cnt + 16'd1;
      end
      if (state == S_CHECK) begin
        pass <= (sig == exp_sig);
        done <= 1'b1;
      end
    end
  end

  // NOTE: the word buffer has no reset; its content is only consumed in FOLD, which a reset leaves.
  always_ff @(posedge clk) begin
    if (take)                 shreg <= PAD_W'(in_data);
    else if (state == S_FOLD) shreg <= shreg >> CHUNK_W;
  end

`ifdef RESP_CAPTURE_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_data <= '0;
    else if (start_run) last_data <= '0;
    else if (take)      last_data <= in_data;
  end
`else
  assign last_data = '0;
`endif

endmodule

// File: tb/tb_resp_signature_collector.sv
// Scoreboard bench for resp_signature_collector: two 64-bit instances with hand-computed signatures
// and one default-size instance checked against a MISR reference model.
module tb_resp_signature_collector;

  typedef struct packed {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } done_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c_rst = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instances A (SEED=0) and B (SEED=80000000)
  logic        a_start = 0, a_valid = 0, b_start = 0, b_valid = 0;
  logic [31:0] a_exp = '0, b_exp = '0;
  logic [63:0] a_data = '0, b_data = '0;
  logic        a_ready, a_busy, a_done, a_pass, b_ready, b_busy, b_done, b_pass;
  logic [31:0] a_sig, b_sig;
  logic [15:0] a_cnt, b_cnt;
  logic [63:0] a_last, b_last;

  // default instance C
  logic         c_start = 0, c_valid = 0;
  logic [31:0]  c_exp = '0;
  logic [634:0] c_data = '0;
  logic         c_ready, c_busy, c_done, c_pass;
  logic [31:0]  c_sig;
  logic [15:0]  c_cnt;
  logic [634:0] c_last;

  resp_signature_collector #(.DATA_W(64), .NUM_SAMPLES(1), .SEED(32'h0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .exp_sig(a_exp), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .sig(a_sig), .sample_cnt(a_cnt), .busy(a_busy), .done(a_done),
    .pass(a_pass), .last_data(a_last));

  resp_signature_collector #(.DATA_W(64), .NUM_SAMPLES(1), .SEED(32'h80000000)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .exp_sig(b_exp), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .sig(b_sig), .sample_cnt(b_cnt), .busy(b_busy), .done(b_done),
    .pass(b_pass), .last_data(b_last));

  resp_signature_collector dut_c (
    .clk(clk), .rst(c_rst), .start(c_start), .exp_sig(c_exp), .in_valid(c_valid), .in_data(c_data),
    .in_ready(c_ready), .sig(c_sig), .sample_cnt(c_cnt), .busy(c_busy), .done(c_done),
    .pass(c_pass), .last_data(c_last));

  logic [31:0] a_sig_q[$], b_sig_q[$];
  done_t       a_done_q[$], b_done_q[$], c_done_q[$];
  logic [31:0] a_sig_prev = '0, b_sig_prev = '0;
  logic        a_done_prev = 0, b_done_prev = 0, c_done_prev = 0;
  logic [31:0] c_model;
  bit          capture_en;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic done_t mk_done(input logic [31:0] s, input logic p, input logic [15:0] c);
    done_t d;
    d.sig = s; d.pass = p; d.cnt = c;
    return d;
  endfunction

  function automatic logic [634:0] c_vec(input int k);
    logic [639:0] w;
    for (int j = 0; j < 20; j++)
      w[j*32 +: 32] = (32'h9E3779B9 * (k + 1)) ^ (j << 8) ^ (32'h5A5A0000 >> (k % 7));
    return w[634:0];
  endfunction

  // Reference MISR: fold each 32-bit slice of the zero-padded word, lowest slice first.
  function automatic logic [31:0] misr_word(input logic [31:0] s, input logic [634:0] word);
    logic [639:0] w;
    logic [31:0]  r;
    w = {5'b0, word};
    r = s;
    for (int j = 0; j < 20; j++)
      r = {r[30:0], 1'b0} ^ (r[31] ? 32'h04C11DB7 : 32'h0) ^ w[j*32 +: 32];
    return r;
  endfunction

  task automatic done_event(input string who, input bit have, input done_t e,
                            input logic [31:0] s, input logic p, input logic [15:0] c);
    check({who, " done event expected"}, have, 1'b1);
    if (have) begin
      check({who, " final sig"}, s, e.sig);
      check({who, " pass"}, p, e.pass);
      check({who, " sample_cnt"}, c, e.cnt);
    end
  endtask

  // Monitors: compare every signature change and every done rising edge against the queues.
  always @(negedge clk) begin
    if (a_sig !== a_sig_prev) begin
      if (a_sig_q.size() > 0) check("a sig step", a_sig, a_sig_q.pop_front());
      else                    check("a sig unexpected change", a_sig, a_sig_prev);
    end
    if (b_sig !== b_sig_prev) begin
      if (b_sig_q.size() > 0) check("b sig step", b_sig, b_sig_q.pop_front());
      else                    check("b sig unexpected change", b_sig, b_sig_prev);
    end
    if (a_done && !a_done_prev) begin
      if (a_done_q.size() > 0) done_event("a", 1'b1, a_done_q.pop_front(), a_sig, a_pass, a_cnt);
      else                     done_event("a", 1'b0, '0, a_sig, a_pass, a_cnt);
    end
    if (b_done && !b_done_prev) begin
      if (b_done_q.size() > 0) done_event("b", 1'b1, b_done_q.pop_front(), b_sig, b_pass, b_cnt);
      else                     done_event("b", 1'b0, '0, b_sig, b_pass, b_cnt);
    end
    if (c_done && !c_done_prev) begin
      if (c_done_q.size() > 0) done_event("c", 1'b1, c_done_q.pop_front(), c_sig, c_pass, c_cnt);
      else                     done_event("c", 1'b0, '0, c_sig, c_pass, c_cnt);
    end
    a_sig_prev  <= a_sig;
    b_sig_prev  <= b_sig;
    a_done_prev <= a_done;
    b_done_prev <= b_done;
    c_done_prev <= c_done;
  end

  task automatic run_c(input int abort_at, input bit glitch);
    int hs, cyc, first_cyc, last_cyc;
    hs = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    if (abort_at < 0) c_done_q.push_back(mk_done(c_model, 1'b1, 16'd22));
    c_exp = c_model;
    @(negedge clk); c_start = 1'b1;
    @(negedge clk); c_start = 1'b0; c_valid = 1'b1; c_data = c_vec(0);
    while (!c_done && cyc < 1200) begin
      if (c_ready) begin
        if (hs == 0) first_cyc = cyc;
        else         check("c ready period", cyc - last_cyc, 21);
        last_cyc = cyc;
        hs++;
      end
      if (abort_at >= 0 && hs == abort_at + 1 && cyc == last_cyc + 3) begin
        #2 c_rst = 1'b1;
        #1;
        check("abort in_ready", c_ready, 1'b0);
        check("abort sig", c_sig, 32'h0);
        check("abort sample_cnt", c_cnt, 16'h0);
        check("abort busy", c_busy, 1'b0);
        check("abort done", c_done, 1'b0);
        check("abort pass", c_pass, 1'b0);
        check("abort last_data", c_last, 635'h0);
        @(negedge clk);
        c_rst = 1'b0; c_valid = 1'b0;
        return;
      end
      c_start = glitch && hs == 3 && cyc == last_cyc + 2;
      if (glitch && hs == 3 && cyc == last_cyc + 3) begin
        check("start in FOLD sample_cnt", c_cnt, 16'd2);
        check("start in FOLD busy", c_busy, 1'b1);
        check("start in FOLD in_ready", c_ready, 1'b0);
      end
      @(negedge clk);
      cyc++;
      c_data = c_vec(hs);
    end
    c_valid = 1'b0;
    check("c done within budget", c_done, 1'b1);
    check("c handshakes", hs, 22);
    check("c done latency", cyc - first_cyc, 463);
    check("c last_data", c_last, capture_en ? c_vec(21) : 635'h0);
  endtask

  initial begin
    int cyc, ready_hi;
`ifdef RESP_CAPTURE_LAST_EN
    capture_en = 1'b1;
`else
    capture_en = 1'b0;
`endif
    c_model = 32'hFFFFFFFF;
    for (int k = 0; k < 22; k++) c_model = misr_word(c_model, c_vec(k));

    #1 rst = 1'b1; c_rst = 1'b1;
    @(negedge clk);
    check("reset in_ready", c_ready, 1'b0);
    check("reset sig", c_sig, 32'h0);
    check("reset sample_cnt", c_cnt, 16'h0);
    check("reset busy", c_busy, 1'b0);
    check("reset done", c_done, 1'b0);
    check("reset pass", c_pass, 1'b0);
    check("reset last_data", c_last, 635'h0);
    check("reset a sig", a_sig, 32'h0);
    @(negedge clk); rst = 1'b0; c_rst = 1'b0;

    // A: SEED=0, word FFFFFFFF_00000001 -> 1, FFFFFFFD, pass
    a_sig_q.push_back(32'h00000001);
    a_sig_q.push_back(32'hFFFFFFFD);
    a_done_q.push_back(mk_done(32'hFFFFFFFD, 1'b1, 16'd1));
    @(negedge clk); a_start = 1'b1; a_exp = 32'hFFFFFFFD; a_data = 64'hFFFFFFFF_00000001;
    @(negedge clk); a_start = 1'b0;
    check("a ready after start", a_ready, 1'b1);
    check("a busy after start", a_busy, 1'b1);
    a_valid = 1'b1;
    cyc = 0; ready_hi = 0;
    while (!a_done && cyc < 50) begin
      @(negedge clk); cyc++; a_valid = 1'b0;
      if (a_ready) ready_hi++;
    end
    check("a done latency", cyc, 4);
    check("a ready low after handshake", ready_hi, 0);
    check("a busy in DONE", a_busy, 1'b0);
    check("a last_data", a_last, capture_en ? 64'hFFFFFFFF_00000001 : 64'h0);

    // B: SEED=80000000, zero word -> 04C11DB7, 09823B6E, exp 0 so fail
    b_sig_q.push_back(32'h80000000);
    b_sig_q.push_back(32'h04C11DB7);
    b_sig_q.push_back(32'h09823B6E);
    b_done_q.push_back(mk_done(32'h09823B6E, 1'b0, 16'd1));
    @(negedge clk); b_start = 1'b1; b_exp = 32'h0; b_data = 64'h0;
    @(negedge clk); b_start = 1'b0; b_valid = 1'b1;
    cyc = 0;
    while (!b_done && cyc < 50) begin
      @(negedge clk); cyc++; b_valid = 1'b0;
    end
    check("b done latency", cyc, 4);
    repeat (3) @(negedge clk);
    check("b done sticky", b_done, 1'b1);
    check("b sig frozen", b_sig, 32'h09823B6E);

    // A restart from DONE: everything clears, sig reloads SEED
    a_sig_q.push_back(32'h0);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check("restart done", a_done, 1'b0);
    check("restart pass", a_pass, 1'b0);
    check("restart sig", a_sig, 32'h0);
    check("restart sample_cnt", a_cnt, 16'h0);
    check("restart in_ready", a_ready, 1'b1);

    // C: reference run with a start glitch in FOLD, aborted run, clean rerun
    run_c(-1, 1'b1);
    run_c(4, 1'b0);
    repeat (5) @(negedge clk);
    check("c idle after abort", c_busy, 1'b0);
    run_c(-1, 1'b0);

    repeat (3) @(negedge clk);
    check("a sig queue drained", a_sig_q.size(), 0);
    check("b sig queue drained", b_sig_q.size(), 0);
    check("a done queue drained", a_done_q.size(), 0);
    check("b done queue drained", b_done_q.size(), 0);
    check("c done queue drained", c_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
